tlb_ctrl: RTL and testbench
===========================

Name: tlb_ctrl

Overview:
- Maintenance engine that owns the TLB entry array and writes it. The CP0 translation lookups are the readers of this array.
- Executes TLBR, TLBWI, TLBWR, TLBP and FLUSH requests from the execute stage through a valid/ready request and a one-cycle response pulse.
- Exports the full entry array in the existing 90-bit entry format for the instruction and data translation lookups, plus the Random register value.

Parameters:
- N, 16, number of TLB entries; must be a power of 2 and at least 2.
- IDX_W, $clog2(N), width of index fields.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active low.
- op_valid  in  1  request valid.
- op_ready  out  1  engine idle; request is accepted on op_valid&op_ready.
- op_code  in  3  0=TLBR, 1=TLBWI, 2=TLBWR, 3=TLBP, 4=FLUSH; 5-7 are illegal.
- index_i  in  IDX_W  Index register value, used by TLBR and TLBWI.
- entryhi_i  in  32  EntryHi.
- entrylo0_i  in  32  EntryLo0.
- entrylo1_i  in  32  EntryLo1.
- pagemask_i  in  32  PageMask.
- wired_i  in  IDX_W  Wired register value.
- resp_valid  out  1  one-cycle completion pulse.
- resp_op  out  3  op_code of the completing request.
- rd_entryhi_o  out  32  TLBR result.
- rd_entrylo0_o  out  32  TLBR result.
- rd_entrylo1_o  out  32  TLBR result.
- rd_pagemask_o  out  32  TLBR result.
- probe_o  out  32  TLBP result: bit31 = miss (P), [IDX_W-1:0] = index, other bits 0.
- random_o  out  IDX_W  current Random value.
- tlb_update_o  out  1  array-changed pulse.
- tlb_entries_o  out  N*90  entry i occupies bits [i*90+89 : i*90].

Behaviour:
- Entry format:
  - [89:71] vpn2 = entryhi[31:13]
  - [70:63] asid = entryhi[7:0]
  - [62:51] mask = pagemask[24:13]
  - [50] G = lo0[0] & lo1[0]
  - [49:30] pfn0 = lo0[25:6]
  - [29:25] flags0 = lo0[5:1], i.e. C[2:0], D, V
  - [24:5] pfn1 = lo1[25:6]
  - [4:0] flags1 = lo1[5:1]
- TLBR read-back format:
  - entryhi = {vpn2, 5'b0, asid}
  - lo0 = {6'b0, pfn0, flags0, G}; lo1 uses the same layout with pfn1/flags1
  - pagemask = {7'b0, mask, 13'b0}
- Reset (async, rst_n low):
  - FSM goes to IDLE; all entries are cleared to 0; random_o = N-1.
  - All outputs are 0, except op_ready=1 once rst_n is high.
  - A reset during any operation aborts it; no resp_valid is issued.
- FSM states: IDLE, PROBE, FLUSH, RESP.
- op_ready=1 only in IDLE. All operands are latched at acceptance; later input changes are ignored.
- Timing is counted from E0, the acceptance edge. Cycle k is the cycle after edge Ek-1.
- TLBWI: entry[index] is written at E0; FSM goes to RESP. resp_valid=1 and tlb_update_o=1 in cycle 1; back to IDLE in cycle 2.
- TLBWR: same as TLBWI, but the index is random_o sampled at E0.
- TLBR: the rd_* registers are loaded from entry[index] at E0. resp_valid in cycle 1; tlb_update_o stays 0.
- TLBP:
  - Cycle j+1 compares entry j.
  - Match rule: ((vpn2_e ^ vpn2_q) & ~{7'b0, mask_e}) == 0 AND (asid_e == asid_q OR G_e).
  - The first match j (lowest index) ends the scan: probe_o = {1'b0, ..., j}, resp_valid in cycle j+2.
  - No match: probe_o = 32'h8000_0000, resp_valid in cycle N+1.
- FLUSH: entry i is cleared at edge Ei. resp_valid=1 and tlb_update_o=1 in cycle N+1.
- Illegal op: no state change; resp_valid in cycle 1; rd_*, probe_o and the array are untouched.
- rd_* and probe_o hold their values until the next TLBR/TLBP completion.
- Array writes become visible on tlb_entries_o in the cycle after the write edge.
- Random:
  - Updates every cycle, independent of the FSM.
  - If random_o <= wired_i, next = N-1; otherwise next = random_o - 1.
  - If wired_i >= N-1, random_o holds at N-1.
  - A TLBWR uses the pre-update value.
- Simultaneous events: a new op_valid during RESP is not accepted; it is accepted in the following IDLE cycle. resp_valid has no backpressure.

Decomposition:
- Package tlb_pkg holds:
  - op code constants TLB_OP_*
  - entry field offsets/widths, or a packed tlb_entry_t of 90 bits
  - pack/unpack functions converting between CP0 registers and tlb_entry_t
- Sub-module tlb_entry_match: combinational vpn2/mask/asid/G compare of one entry. It is shared with the translation lookups.

Test Plan:
- Write/read-back: TLBWI index=3, entryhi=0x0040_2005, lo0=0x0000_1047, lo1=0x0000_1087, pagemask=0 -> cycle 1 resp_valid with tlb_update_o. Then TLBR index=3 -> rd_entryhi=0x0040_2005, rd_entrylo0=0x0000_1047, rd_entrylo1=0x0000_1087, rd_pagemask=0.
- Probe hit/miss: entries 2 and 5 both match VPN2 0x00201 with G=1, queried with ASID 0x09 -> probe_o=2, resp_valid in cycle 4. Query VPN2 0x7FFFF -> probe_o=0x8000_0000, resp_valid in cycle N+1=17.
- Pagemask match: entry with mask 0x003 and vpn2 0x00200, probe vpn2 0x00203 -> hit; probe vpn2 0x00204 -> miss.
- Random/wired: wired_i=4, random sequence after reset is 15,14,...,4,15; TLBWR writes the index equal to the random_o value sampled at acceptance.
- FLUSH: after writing all 16 entries -> resp_valid and tlb_update_o in cycle 17; tlb_entries_o is all zero; op_ready=0 throughout.
- Reset mid-PROBE: rst_n low in cycle 5 -> no resp_valid, entries zero, random_o=15. Illegal op_code 6 -> resp_valid in cycle 1 and the array is unchanged.

Source files
------------

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB maintenance engine and the
// translation lookups.
//   - TLB_OP_* : request op codes accepted by tlb_ctrl (5-7 are illegal).
//   - tlb_entry_t : the 90-bit packed entry layout exported on tlb_entries_o.
//   - tlb_pack / tlb_rd_* : conversion between CP0 register images and entries.
//   - tlb_state_e : tlb_ctrl FSM states.
package tlb_pkg;

  localparam logic [2:0] TLB_OP_TLBR  = 3'd0;
  localparam logic [2:0] TLB_OP_TLBWI = 3'd1;
  localparam logic [2:0] TLB_OP_TLBWR = 3'd2;
  localparam logic [2:0] TLB_OP_TLBP  = 3'd3;
  localparam logic [2:0] TLB_OP_FLUSH = 3'd4;

  localparam int TLB_ENTRY_W = 90;

  // Field order gives vpn2 at [89:71] down to flags1 at [4:0].
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic [11:0] mask;
    logic        g;
    logic [19:0] pfn0;
    logic [4:0]  flags0;
    logic [19:0] pfn1;
    logic [4:0]  flags1;
  } tlb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RESP  = 2'd3
  } tlb_state_e;

  // Build an entry from EntryHi/EntryLo0/EntryLo1/PageMask.
  // G is stored once: it is set only if both halves are global.
  function automatic tlb_entry_t tlb_pack(input logic [31:0] hi, input logic [31:0] lo0,
                                          input logic [31:0] lo1, input logic [31:0] pm);
    tlb_entry_t e;
    logic       unused_bits;
    e.vpn2   = hi[31:13];
    e.asid   = hi[7:0];
    e.mask   = pm[24:13];
    e.g      = lo0[0] & lo1[0];
    e.pfn0   = lo0[25:6];
    e.flags0 = lo0[5:1];
    e.pfn1   = lo1[25:6];
    e.flags1 = lo1[5:1];
    unused_bits = ^{hi[12:8], lo0[31:26], lo1[31:26], pm[31:25], pm[12:0]};
    return e;
  endfunction

  function automatic logic [31:0] tlb_rd_hi(input tlb_entry_t e);
    return {e.vpn2, 5'b0, e.asid};
  endfunction

  function automatic logic [31:0] tlb_rd_lo0(input tlb_entry_t e);
    return {6'b0, e.pfn0, e.flags0, e.g};
  endfunction

  function automatic logic [31:0] tlb_rd_lo1(input tlb_entry_t e);
    return {6'b0, e.pfn1, e.flags1, e.g};
  endfunction

  function automatic logic [31:0] tlb_rd_pm(input tlb_entry_t e);
    return {7'b0, e.mask, 13'b0};
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// tlb_entry_match: combinational hit test of one TLB entry against a
// VPN2/ASID pair. Shared by the probe scan and the translation lookups.
//   entry_i  : entry under test
//   vpn2_i   : virtual page number / 2 being looked up
//   asid_i   : current address space id
//   match_o  : 1 when VPN2 agrees outside the page mask and ASID agrees or G
module tlb_entry_match
  import tlb_pkg::*;
(
  input  tlb_entry_t  entry_i,
  input  logic [18:0] vpn2_i,
  input  logic [7:0]  asid_i,
  output logic        match_o
);

  logic vpn_hit;
  logic unused_fields;

  // Mask bits mark VPN2 bits that belong to the page offset of a large page.
  assign vpn_hit = ((entry_i.vpn2 ^ vpn2_i) & ~{7'b0, entry_i.mask}) == 19'd0;
  assign match_o = vpn_hit && ((entry_i.asid == asid_i) || entry_i.g);

  assign unused_fields = ^{entry_i.pfn0, entry_i.flags0, entry_i.pfn1, entry_i.flags1};

endmodule

// File: rtl/tlb_ctrl.sv
// tlb_ctrl: TLB maintenance engine. Owns the entry array and executes
// TLBR / TLBWI / TLBWR / TLBP / FLUSH requests.
//   op_valid/op_ready/op_code : request handshake; accepted on op_valid&op_ready
//   index_i, entryhi_i, entrylo0_i, entrylo1_i, pagemask_i : operands (latched)
//   wired_i        : Wired register, lower bound of the Random range
//   resp_valid/resp_op : one-cycle completion pulse and the completing op
//   rd_*_o         : TLBR result registers      probe_o : TLBP result
//   random_o       : Random register            tlb_update_o : array changed
//   tlb_entries_o  : whole array, entry i at [i*90 +: 90]
// Handshake: op_ready is high only in IDLE; a request is taken on the edge
// where op_valid and op_ready are both high; resp_valid has no backpressure.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op_code,
  input  logic [IDX_W-1:0]       index_i,
  input  logic [31:0]            entryhi_i,
  input  logic [31:0]            entrylo0_i,
  input  logic [31:0]            entrylo1_i,
  input  logic [31:0]            pagemask_i,
  input  logic [IDX_W-1:0]       wired_i,
  output logic                   resp_valid,
  output logic [2:0]             resp_op,
  output logic [31:0]            rd_entryhi_o,
  output logic [31:0]            rd_entrylo0_o,
  output logic [31:0]            rd_entrylo1_o,
  output logic [31:0]            rd_pagemask_o,
  output logic [31:0]            probe_o,
  output logic [IDX_W-1:0]       random_o,
  output logic                   tlb_update_o,
  output logic [N*TLB_ENTRY_W-1:0] tlb_entries_o
);

  tlb_state_e       state_q, state_d;
  tlb_entry_t       entries_q [N];
  tlb_entry_t       rd_entry_q;
  tlb_entry_t       scan_entry;
  tlb_entry_t       wr_data;
  logic [2:0]       op_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] random_q;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      probe_q;
  logic [18:0]      vpn2_q;
  logic [7:0]       asid_q;
  logic             accept, scan_hit, scan_last, wr_en;

  assign accept     = op_valid & op_ready;
  assign scan_entry = entries_q[cnt_q];
  assign scan_last  = (cnt_q == IDX_W'(N - 1));

  tlb_entry_match u_match (
    .entry_i (scan_entry),
    .vpn2_i  (vpn2_q),
    .asid_i  (asid_q),
    .match_o (scan_hit)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_code == TLB_OP_TLBP)       state_d = ST_PROBE;
          else if (op_code == TLB_OP_FLUSH) state_d = ST_FLUSH;
          else                              state_d = ST_RESP;
        end
      end
      ST_PROBE: if (scan_hit || scan_last) state_d = ST_RESP;
      // cnt_q wraps to 0 after the last entry is cleared.
      ST_FLUSH: if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    op_ready     = rst_n && (state_q == ST_IDLE);
    resp_valid   = (state_q == ST_RESP);
    tlb_update_o = (state_q == ST_RESP) &&
                   (op_q inside {TLB_OP_TLBWI, TLB_OP_TLBWR, TLB_OP_FLUSH});
  end

  // Single array write port: TLBWI/TLBWR/first flush clear on acceptance,
  // remaining flush clears one entry per cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = index_i;
    wr_data = tlb_pack(entryhi_i, entrylo0_i, entrylo1_i, pagemask_i);
    if (accept) begin
      if (op_code == TLB_OP_TLBWI) begin
        wr_en = 1'b1;
      end else if (op_code == TLB_OP_TLBWR) begin
        wr_en  = 1'b1;
        wr_idx = random_q;
      end else if (op_code == TLB_OP_FLUSH) begin
        wr_en   = 1'b1;
        wr_idx  = '0;
        wr_data = '0;
      end
    end else if (state_q == ST_FLUSH && cnt_q != '0) begin
      wr_en   = 1'b1;
      wr_idx  = cnt_q;
      wr_data = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) entries_q[i] <= '0;
    end else if (wr_en) begin
      entries_q[wr_idx] <= wr_data;
    end
  end

  // Operand latches, scan counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      cnt_q      <= '0;
      vpn2_q     <= '0;
      asid_q     <= '0;
      rd_entry_q <= '0;
      probe_q    <= '0;
    end else if (accept) begin
      op_q <= op_code;
      if (op_code == TLB_OP_TLBR) begin
        rd_entry_q <= entries_q[index_i];
      end else if (op_code == TLB_OP_TLBP) begin
        vpn2_q <= entryhi_i[31:13];
        asid_q <= entryhi_i[7:0];
        cnt_q  <= '0;
      end else if (op_code == TLB_OP_FLUSH) begin
        cnt_q <= IDX_W'(1);
      end
    end else if (state_q == ST_PROBE) begin
      if (scan_hit)       probe_q <= 32'(cnt_q);
      else if (scan_last) probe_q <= 32'h8000_0000;
      cnt_q <= cnt_q + IDX_W'(1);
    end else if (state_q == ST_FLUSH) begin
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  // Random counts down every cycle and reloads N-1 once it reaches Wired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   random_q <= IDX_W'(N - 1);
    else if (random_q <= wired_i) random_q <= IDX_W'(N - 1);
    else                          random_q <= random_q - IDX_W'(1);
  end

  assign resp_op       = op_q;
  assign rd_entryhi_o  = tlb_rd_hi(rd_entry_q);
  assign rd_entrylo0_o = tlb_rd_lo0(rd_entry_q);
  assign rd_entrylo1_o = tlb_rd_lo1(rd_entry_q);
  assign rd_pagemask_o = tlb_rd_pm(rd_entry_q);
  assign probe_o       = probe_q;
  assign random_o      = random_q;

  for (genvar i = 0; i < N; i++) begin : g_export
    assign tlb_entries_o[i*TLB_ENTRY_W +: TLB_ENTRY_W] = entries_q[i];
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// tb_tlb_ctrl: self-checking bench for tlb_ctrl. Keeps a register-image
// reference of every entry, a Random model and the expected result registers.
module tb_tlb_ctrl;

  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int EW    = 90;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [2:0]        op_code = '0;
  logic [IDX_W-1:0]  index_i = '0;
  logic [31:0]       entryhi_i = '0, entrylo0_i = '0, entrylo1_i = '0, pagemask_i = '0;
  logic [IDX_W-1:0]  wired_i = 4'd4;
  logic              resp_valid;
  logic [2:0]        resp_op;
  logic [31:0]       rd_entryhi_o, rd_entrylo0_o, rd_entrylo1_o, rd_pagemask_o, probe_o;
  logic [IDX_W-1:0]  random_o;
  logic              tlb_update_o;
  logic [N*EW-1:0]   tlb_entries_o;

  always #5 clk = ~clk;

  tlb_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .index_i(index_i), .entryhi_i(entryhi_i),
    .entrylo0_i(entrylo0_i), .entrylo1_i(entrylo1_i), .pagemask_i(pagemask_i),
    .wired_i(wired_i), .resp_valid(resp_valid), .resp_op(resp_op),
    .rd_entryhi_o(rd_entryhi_o), .rd_entrylo0_o(rd_entrylo0_o),
    .rd_entrylo1_o(rd_entrylo1_o), .rd_pagemask_o(rd_pagemask_o),
    .probe_o(probe_o), .random_o(random_o), .tlb_update_o(tlb_update_o),
    .tlb_entries_o(tlb_entries_o)
  );

  // ---------------- reference model ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_hi [N];
  logic [31:0] m_lo0[N];
  logic [31:0] m_lo1[N];
  logic [31:0] m_pm [N];
  logic [31:0] e_rd_hi, e_rd_lo0, e_rd_lo1, e_rd_pm, e_probe;
  int          m_rand;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                m_rand = N - 1;
    else if (m_rand <= wired_i) m_rand = N - 1;
    else                       m_rand = m_rand - 1;
  end

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Random register watched every cycle against the model.
  always @(negedge clk) begin
    #2;
    if (rst_n) check("random", 96'(random_o), 96'(m_rand));
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; m_pm[i] = '0;
    end
    e_rd_hi = '0; e_rd_lo0 = '0; e_rd_lo1 = '0; e_rd_pm = '0; e_probe = '0;
  endtask

  function automatic logic [89:0] exp_entry(input int i);
    return {m_hi[i][31:13], m_hi[i][7:0], m_pm[i][24:13], m_lo0[i][0] & m_lo1[i][0],
            m_lo0[i][25:6], m_lo0[i][5:1], m_lo1[i][25:6], m_lo1[i][5:1]};
  endfunction

  // Lowest-index entry whose unmasked VPN2 bits agree and whose ASID agrees or is global.
  function automatic int probe_model(input logic [31:0] q);
    logic [18:0] mk;
    for (int j = 0; j < N; j++) begin
      mk = {7'b0, m_pm[j][24:13]};
      if (((m_hi[j][31:13] | mk) == (q[31:13] | mk)) &&
          ((m_hi[j][7:0] == q[7:0]) || (m_lo0[j][0] && m_lo1[j][0])))
        return j;
    end
    return -1;
  endfunction

  task automatic check_array(input string tag);
    for (int i = 0; i < N; i++)
      check($sformatf("%s_entry%0d", tag, i), 96'(tlb_entries_o[i*EW +: EW]), 96'(exp_entry(i)));
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_rd_hi"},  96'(rd_entryhi_o),  96'(e_rd_hi));
    check({tag, "_rd_lo0"}, 96'(rd_entrylo0_o), 96'(e_rd_lo0));
    check({tag, "_rd_lo1"}, 96'(rd_entrylo1_o), 96'(e_rd_lo1));
    check({tag, "_rd_pm"},  96'(rd_pagemask_o), 96'(e_rd_pm));
    check({tag, "_probe"},  96'(probe_o),       96'(e_probe));
  endtask

  // ---------------- driver ----------------
  // Issues one request (entered and left on a negedge), returns the cycle of resp_valid.
  task automatic run_op(input logic [2:0] code, input logic [3:0] idx, input logic [31:0] hi,
                        input logic [31:0] lo0, input logic [31:0] lo1, input logic [31:0] pm,
                        output int got_cyc);
    int guard, exp_cyc, busy_bad, wr_idx, hit;
    logic g;
    guard = 0;
    while (op_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("op_ready_idle", 96'(op_ready), 96'(1));
    wr_idx = (code == 3'd2) ? m_rand : int'(idx);
    hit    = probe_model(hi);
    op_valid = 1'b1; op_code = code; index_i = idx;
    entryhi_i = hi; entrylo0_i = lo0; entrylo1_i = lo1; pagemask_i = pm;
    @(posedge clk);
    #1;
    // Operands must have been latched; scramble them.
    op_valid = 1'b0; op_code = 3'($urandom); index_i = 4'($urandom);
    entryhi_i = $urandom; entrylo0_i = $urandom; entrylo1_i = $urandom; pagemask_i = $urandom;
    case (code)
      3'd0: begin
        g = m_lo0[idx][0] & m_lo1[idx][0];
        e_rd_hi  = {m_hi[idx][31:13], 5'b0, m_hi[idx][7:0]};
        e_rd_lo0 = {6'b0, m_lo0[idx][25:1], g};
        e_rd_lo1 = {6'b0, m_lo1[idx][25:1], g};
        e_rd_pm  = {7'b0, m_pm[idx][24:13], 13'b0};
        exp_cyc  = 1;
      end
      3'd1, 3'd2: begin
        m_hi[wr_idx] = hi; m_lo0[wr_idx] = lo0; m_lo1[wr_idx] = lo1; m_pm[wr_idx] = pm;
        exp_cyc = 1;
      end
      3'd3: begin
        e_probe = (hit < 0) ? 32'h8000_0000 : 32'(hit);
        exp_cyc = (hit < 0) ? N + 1 : hit + 2;
      end
      3'd4: begin
        for (int i = 0; i < N; i++) begin
          m_hi[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0; m_pm[i] = '0;
        end
        exp_cyc = N + 1;
      end
      default: exp_cyc = 1;
    endcase
    got_cyc  = -1;
    busy_bad = 0;
    for (int k = 1; k <= N + 8; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        got_cyc = k;
        check("resp_op", 96'(resp_op), 96'(code));
        check("tlb_update", 96'(tlb_update_o), 96'(code == 3'd1 || code == 3'd2 || code == 3'd4));
        break;
      end
      if (op_ready !== 1'b0) busy_bad++;
      if (tlb_update_o !== 1'b0) busy_bad++;
    end
    check($sformatf("resp_cycle_op%0d", code), 96'(got_cyc), 96'(exp_cyc));
    check("busy_no_ready_no_update", 96'(busy_bad), 96'(0));
    @(negedge clk);
    check("resp_pulse_end", 96'(resp_valid), 96'(0));
    check_regs("after_op");
    check_array("after_op");
  endtask

  function automatic logic [31:0] rand_hi();
    logic [18:0] v;
    v = 19'(32'h200 + $urandom_range(0, 7));
    return {v, 5'($urandom), 8'($urandom_range(0, 3))};
  endfunction

  function automatic logic [31:0] rand_pm();
    logic [11:0] mk;
    case ($urandom_range(0, 3))
      0: mk = 12'h000;
      1: mk = 12'h001;
      2: mk = 12'h003;
      default: mk = 12'hFFF;
    endcase
    return ($urandom & ~32'h01FF_E000) | {7'b0, mk, 13'b0};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int cyc, r, quiet_bad;
    logic [2:0] c;
    model_reset();
    #12;
    check("reset_op_ready", 96'(op_ready), 96'(0));
    check("reset_resp_valid", 96'(resp_valid), 96'(0));
    check("reset_update", 96'(tlb_update_o), 96'(0));
    check("reset_random", 96'(random_o), 96'(15));
    check_regs("reset");
    check_array("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 96'(op_ready), 96'(1));

    // Random sequence with Wired=4: 15,14,...,4,15,...
    for (int k = 0; k < 14; k++) begin
      check("rand_seq", 96'(random_o), 96'(15 - (k % 12)));
      @(negedge clk);
    end

    // Write / read-back
    run_op(3'd1, 4'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0, cyc);
    check("tlbwi_cycle", 96'(cyc), 96'(1));
    run_op(3'd0, 4'd3, 32'h0, 32'h0, 32'h0, 32'h0, cyc);
    check("tlbr_hi",  96'(rd_entryhi_o),  96'(32'h0040_2005));
    check("tlbr_lo0", 96'(rd_entrylo0_o), 96'(32'h0000_1047));
    check("tlbr_lo1", 96'(rd_entrylo1_o), 96'(32'h0000_1087));
    check("tlbr_pm",  96'(rd_pagemask_o), 96'(32'h0));

    // Probe hit (lowest index wins) and miss
    run_op(3'd1, 4'd2, 32'h0040_2033, 32'h0000_2041, 32'h0000_3001, 32'h0, cyc);
    run_op(3'd1, 4'd5, 32'h0040_2044, 32'h0000_4081, 32'h0000_5001, 32'h0, cyc);
    run_op(3'd3, 4'd0, 32'h0040_2009, 32'h0, 32'h0, 32'h0, cyc);
    check("probe_hit_idx", 96'(probe_o), 96'(2));
    check("probe_hit_cycle", 96'(cyc), 96'(4));
    run_op(3'd3, 4'd0, 32'hFFFF_E009, 32'h0, 32'h0, 32'h0, cyc);
    check("probe_miss_val", 96'(probe_o), 96'(32'h8000_0000));
    check("probe_miss_cycle", 96'(cyc), 96'(17));

    // Page mask
    run_op(3'd1, 4'd7, {19'h00200, 13'h0011}, 32'h0000_0040, 32'h0000_0081, 32'h0000_6000, cyc);
    run_op(3'd3, 4'd0, {19'h00203, 13'h0011}, 32'h0, 32'h0, 32'h0, cyc);
    check("mask_hit", 96'(probe_o), 96'(7));
    run_op(3'd3, 4'd0, {19'h00204, 13'h0011}, 32'h0, 32'h0, 32'h0, cyc);
    check("mask_miss", 96'(probe_o), 96'(32'h8000_0000));

    // TLBWR uses Random at acceptance (model predicts the slot)
    run_op(3'd2, 4'd0, 32'h1234_5067, 32'h0ABC_DEF3, 32'h0135_7919, 32'h0, cyc);

    // Randomized mix
    for (int n = 0; n < 70; n++) begin
      if ($urandom_range(0, 4) == 0) wired_i = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      if (r <= 2)      c = 3'd1;
      else if (r == 3) c = 3'd2;
      else if (r <= 5) c = 3'd0;
      else if (r <= 8) c = 3'd3;
      else             c = 3'($urandom_range(5, 7));
      run_op(c, 4'($urandom), rand_hi(), $urandom, $urandom, rand_pm(), cyc);
    end

    // Flush after filling every entry
    for (int i = 0; i < N; i++)
      run_op(3'd1, 4'(i), rand_hi(), $urandom, $urandom, rand_pm(), cyc);
    run_op(3'd4, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, cyc);
    check("flush_cycle", 96'(cyc), 96'(17));
    check("flush_all_zero", 96'(|tlb_entries_o), 96'(0));

    // Reset in the middle of a probe scan
    run_op(3'd1, 4'd11, 32'h0040_2077, 32'h0000_1041, 32'h0000_1001, 32'h0, cyc);
    op_valid = 1'b1; op_code = 3'd3; entryhi_i = 32'hFFFF_E009;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    quiet_bad = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) quiet_bad++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      #2;
      if (resp_valid !== 1'b0) quiet_bad++;
      check("midreset_ready", 96'(op_ready), 96'(0));
      check("midreset_random", 96'(random_o), 96'(15));
      @(negedge clk);
    end
    check_array("midreset");
    check_regs("midreset");
    rst_n = 1'b1;
    #1;
    check("ready_after_midreset", 96'(op_ready), 96'(1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) quiet_bad++;
    end
    check("no_resp_after_abort", 96'(quiet_bad), 96'(0));

    // Illegal op leaves everything alone
    run_op(3'd1, 4'd9, 32'h0040_4055, 32'h0000_2247, 32'h0000_3387, 32'h0000_2000, cyc);
    run_op(3'd0, 4'd9, 32'h0, 32'h0, 32'h0, 32'h0, cyc);
    run_op(3'd6, 4'd9, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("illegal_cycle", 96'(cyc), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
